// File: rtl/bsg_manycore_host_req_scheduler.sv
// ---------------------------------------------------------------------------
// bsg_manycore_host_req_scheduler
//
// Shares one host-request / manycore-response FIFO pair of the manycore link
// endpoint bridge between num_req_p host-side requesters. Requests are
// round-robin arbitrated onto the endpoint request FIFO. Each remote load is
// tagged with the requester index in the upper load_id bits, and returned
// load data is routed back to the owning requester with that tag cleared.
// Outstanding loads are limited per requester, and a fence drains all
// in-flight traffic.
//
// Ports
//   clk_i, reset_i     clock, synchronous active-high reset
//   req_v_i/req_data_i/req_ready_o        per-requester request channel
//   rsp_v_o/rsp_data_o/rsp_ready_i        per-requester response channel
//                                          (data bus shared, valid one-hot)
//   mc_req_v_o/mc_req_data_o/mc_req_ready_i  to endpoint host-request FIFO
//   mc_rsp_v_i/mc_rsp_data_i/mc_rsp_ready_o  from endpoint mc-response FIFO
//   out_credits_i      endpoint out credits (full == max_out_credits_p)
//   fence_i            level drain request; fence_done_o when drained
//   err_o              sticky: unroutable or unexpected response seen
//
// Packet layout (LSB first)
//   request : x_dst[7:0] y_dst[15:8] x_src[23:16] y_src[31:24]
//             payload[63:32] reg_id[71:64] op_v2[79:72] addr[111:80]
//   response: x_dst[7:0] y_dst[15:8] op_v2[23:16] load_id[55:24] data[87:56]
// ---------------------------------------------------------------------------
module bsg_manycore_host_req_scheduler #(
  parameter int num_req_p         = 2,
  parameter int fifo_width_p      = 128,
  parameter int max_out_credits_p = 16,
  parameter int load_id_width_p   = 12,
  parameter int max_outstanding_p = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p-1:0][fifo_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]                   req_ready_o,

  output logic [num_req_p-1:0]                   rsp_v_o,
  output logic [fifo_width_p-1:0]                rsp_data_o,
  input  logic [num_req_p-1:0]                   rsp_ready_i,

  output logic                                   mc_req_v_o,
  output logic [fifo_width_p-1:0]                mc_req_data_o,
  input  logic                                   mc_req_ready_i,

  input  logic                                   mc_rsp_v_i,
  input  logic [fifo_width_p-1:0]                mc_rsp_data_i,
  output logic                                   mc_rsp_ready_o,

  input  logic [$clog2(max_out_credits_p+1)-1:0] out_credits_i,
  input  logic                                   fence_i,
  output logic                                   fence_done_o,
  output logic                                   err_o
);

  localparam int idx_w  = $clog2(num_req_p);
  localparam int cnt_w  = $clog2(max_outstanding_p + 1);
  localparam int cred_w = $clog2(max_out_credits_p + 1);

  localparam int req_payload_lsb = 32;
  localparam int req_op_lsb      = 72;
  localparam int rsp_load_id_lsb = 24;
  localparam logic [7:0] op_remote_load = 8'd0;

  // The requester index lives in the top idx_w bits of the load_id field.
  localparam int req_tag_lsb = req_payload_lsb + load_id_width_p - idx_w;
  localparam int rsp_tag_lsb = rsp_load_id_lsb + load_id_width_p - idx_w;

  typedef enum logic [1:0] {
    e_idle,   // no grant held
    e_lock,   // grant held until the endpoint accepts it
    e_fence   // no new grants while draining
  } state_e;

  state_e               state_r;
  logic [idx_w-1:0]     rr_ptr_r;
  logic [idx_w-1:0]     lock_idx_r;
  logic [cnt_w-1:0]     cnt_r [num_req_p];
  logic                 err_r;

  // -------------------------------------------------------------------------
  // Eligibility: a load from a requester at its outstanding limit must wait.
  // -------------------------------------------------------------------------
  logic [num_req_p-1:0] is_load;
  logic [num_req_p-1:0] eligible;

  // NOTE: every signal driven from always_comb gets a default assignment first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_load  = '0;
    eligible = '0;
    for (int i = 0; i < num_req_p; i++) begin
      is_load[i]  = (req_data_i[i][req_op_lsb +: 8] == op_remote_load);
      eligible[i] = req_v_i[i]
                    & ~(is_load[i] & (cnt_r[i] == cnt_w'(max_outstanding_p)));
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin search: first eligible requester at or after rr_ptr_r.
  // -------------------------------------------------------------------------
  logic             arb_found;
  logic [idx_w-1:0] arb_idx;
  logic [idx_w-1:0] arb_cand;
  int               cand_sum;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    cand_sum  = 0;
    for (int k = 0; k < num_req_p; k++) begin
      cand_sum = int'(rr_ptr_r) + k;
      if (cand_sum >= num_req_p) cand_sum = cand_sum - num_req_p;
      arb_cand = idx_w'(cand_sum);
      if (!arb_found && eligible[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant selection. In LOCK the held winner is driven regardless of the
  // other requesters so valid and data stay stable until the handshake.
  // -------------------------------------------------------------------------
  logic             sel_v;
  logic [idx_w-1:0] sel_idx;
  logic [idx_w-1:0] next_ptr;
  logic             mc_req_hs;

  always_comb begin
    sel_v   = 1'b0;
    sel_idx = arb_idx;
    case (state_r)
      e_idle: begin
        sel_v   = arb_found & ~fence_i;
        sel_idx = arb_idx;
      end
      e_lock: begin
        sel_v   = 1'b1;
        sel_idx = lock_idx_r;
      end
      default: begin
        sel_v   = 1'b0;
        sel_idx = arb_idx;
      end
    endcase
    if (reset_i) sel_v = 1'b0;
  end

  assign next_ptr  = (sel_idx == idx_w'(num_req_p - 1)) ? '0 : sel_idx + 1'b1;
  assign mc_req_hs = sel_v & mc_req_ready_i;
  assign mc_req_v_o = sel_v;

  always_comb begin
    mc_req_data_o = req_data_i[sel_idx];
    if (is_load[sel_idx]) mc_req_data_o[req_tag_lsb +: idx_w] = sel_idx;
  end

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_ready_o[i] = sel_v & (sel_idx == idx_w'(i)) & mc_req_ready_i;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing. A response whose tag names no requester, or names one
  // with nothing outstanding, is accepted and dropped, and flags an error.
  // -------------------------------------------------------------------------
  logic [idx_w-1:0] rsp_idx;
  logic             routable;

  assign rsp_idx  = mc_rsp_data_i[rsp_tag_lsb +: idx_w];
  assign routable = (int'(rsp_idx) < num_req_p) && (cnt_r[rsp_idx] != '0);

  always_comb begin
    rsp_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rsp_v_o[i] = ~reset_i & mc_rsp_v_i & routable & (rsp_idx == idx_w'(i));
    end
  end

  assign mc_rsp_ready_o = ~reset_i & (routable ? rsp_ready_i[rsp_idx] : 1'b1);

  always_comb begin
    rsp_data_o = mc_rsp_data_i;
    rsp_data_o[rsp_tag_lsb +: idx_w] = '0;
  end

  // -------------------------------------------------------------------------
  // Outstanding-load accounting and fence status.
  // -------------------------------------------------------------------------
  logic [num_req_p-1:0] cnt_inc;
  logic [num_req_p-1:0] cnt_dec;
  logic                 all_cnt_zero;

  always_comb begin
    cnt_inc      = '0;
    cnt_dec      = '0;
    all_cnt_zero = 1'b1;
    for (int i = 0; i < num_req_p; i++) begin
      cnt_inc[i] = mc_req_hs & (sel_idx == idx_w'(i)) & is_load[i];
      cnt_dec[i] = rsp_v_o[i] & rsp_ready_i[i];
      if (cnt_r[i] != '0) all_cnt_zero = 1'b0;
    end
  end

  assign fence_done_o = ~reset_i & (state_r == e_fence)
                        & (out_credits_i == cred_w'(max_out_credits_p))
                        & all_cnt_zero;

  assign err_o = err_r;

  // -------------------------------------------------------------------------
  // Registered state.
  // -------------------------------------------------------------------------
  // NOTE: reset is synchronous: it is only sampled at the clock edge inside
  // this always_ff, so it is not in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      rr_ptr_r   <= '0;
      lock_idx_r <= '0;
      err_r      <= 1'b0;
      // NOTE: the counters are a handful of flops, not a RAM, so they are
      // cleared individually; a grant lost mid-LOCK takes its history with it.
      for (int i = 0; i < num_req_p; i++) cnt_r[i] <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (fence_i) begin
            state_r <= e_fence;
          end else if (arb_found) begin
            if (mc_req_ready_i) begin
              rr_ptr_r <= next_ptr;
            end else begin
              state_r    <= e_lock;
              lock_idx_r <= arb_idx;
            end
          end
        end
        e_lock: begin
          if (mc_req_ready_i) begin
            rr_ptr_r <= next_ptr;
            state_r  <= fence_i ? e_fence : e_idle;
          end
        end
        e_fence: begin
          if (!fence_i) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase

      for (int i = 0; i < num_req_p; i++) begin
        if (cnt_inc[i] & ~cnt_dec[i])      cnt_r[i] <= cnt_r[i] + 1'b1;
        else if (~cnt_inc[i] & cnt_dec[i]) cnt_r[i] <= cnt_r[i] - 1'b1;
      end

      if (mc_rsp_v_i & ~routable) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_host_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_host_req_scheduler
//
// Directed bench for the host request scheduler (2 requesters). Expected
// endpoint requests and requester responses are queued when stimulus is
// driven and popped by negedge monitors on each handshake.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_host_req_scheduler;

  localparam int n_p = 2;
  localparam int w_p = 128;
  localparam logic [7:0] op_ld = 8'd0;
  localparam logic [7:0] op_st = 8'd1;

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic [n_p-1:0]           req_v;
  logic [n_p-1:0][w_p-1:0]  req_data;
  logic [n_p-1:0]           req_ready_o;
  logic [n_p-1:0]           rsp_v_o;
  logic [w_p-1:0]           rsp_data_o;
  logic [n_p-1:0]           rsp_ready;
  logic                     mc_req_v_o;
  logic [w_p-1:0]           mc_req_data_o;
  logic                     mc_req_ready;
  logic                     mc_rsp_v;
  logic [w_p-1:0]           mc_rsp_data;
  logic                     mc_rsp_ready_o;
  logic [4:0]               out_credits;
  logic                     fence;
  logic                     fence_done_o;
  logic                     err_o;

  always #5 clk = ~clk;

  bsg_manycore_host_req_scheduler #(
    .num_req_p        (n_p),
    .fifo_width_p     (w_p),
    .max_out_credits_p(16),
    .load_id_width_p  (12),
    .max_outstanding_p(8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_v_i       (req_v),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready_o),
    .rsp_v_o       (rsp_v_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_ready_i   (rsp_ready),
    .mc_req_v_o    (mc_req_v_o),
    .mc_req_data_o (mc_req_data_o),
    .mc_req_ready_i(mc_req_ready),
    .mc_rsp_v_i    (mc_rsp_v),
    .mc_rsp_data_i (mc_rsp_data),
    .mc_rsp_ready_o(mc_rsp_ready_o),
    .out_credits_i (out_credits),
    .fence_i       (fence),
    .fence_done_o  (fence_done_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic [n_p-1:0] oh;
    logic [w_p-1:0] data;
  } exp_t;

  exp_t req_q[$];
  exp_t rsp_q[$];
  exp_t req_e;
  exp_t rsp_e;

  int n_checks = 0;
  int n_pass   = 0;
  int gcnt0    = 0;
  int gcnt1    = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_req(input logic [7:0] op,
                                          input logic [31:0] payload,
                                          input logic [31:0] addr,
                                          input logic [7:0] src);
    logic [127:0] p;
    p          = '0;
    p[7:0]     = 8'h01;
    p[15:8]    = 8'h02;
    p[23:16]   = src;
    p[31:24]   = 8'h00;
    p[63:32]   = payload;
    p[71:64]   = 8'h05;
    p[79:72]   = op;
    p[111:80]  = addr;
    p[127:112] = 16'hC3C3;
    return p;
  endfunction

  function automatic logic [127:0] mk_rsp(input logic [31:0] load_id,
                                          input logic [31:0] data);
    logic [127:0] p;
    p          = '0;
    p[7:0]     = 8'h03;
    p[15:8]    = 8'h04;
    p[23:16]   = op_ld;
    p[55:24]   = load_id;
    p[87:56]   = data;
    p[127:120] = 8'hA5;
    return p;
  endfunction

  // Endpoint request monitor.
  always @(negedge clk) begin
    if (!reset_i && mc_req_v_o && mc_req_ready) begin
      gcnt0 += int'(req_ready_o[0]);
      gcnt1 += int'(req_ready_o[1]);
      check("req_expected", 128'(req_q.size() > 0), 128'(1));
      if (req_q.size() > 0) begin
        req_e = req_q.pop_front();
        check("req_grant", 128'(req_ready_o), 128'(req_e.oh));
        check("req_data", mc_req_data_o, req_e.data);
      end
    end
  end

  // Requester response monitor.
  always @(negedge clk) begin
    if (!reset_i && ((rsp_v_o & rsp_ready) != '0)) begin
      check("rsp_expected", 128'(rsp_q.size() > 0), 128'(1));
      check("rsp_mc_ready", 128'(mc_rsp_ready_o), 128'(1));
      if (rsp_q.size() > 0) begin
        rsp_e = rsp_q.pop_front();
        check("rsp_route", 128'(rsp_v_o), 128'(rsp_e.oh));
        check("rsp_data", rsp_data_o, rsp_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] ld0;
    logic [127:0] ld0_exp;

    // ---------------- reset with busy inputs ----------------
    reset_i      = 1'b1;
    req_v        = 2'b11;
    req_data     = '0;
    rsp_ready    = 2'b11;
    mc_req_ready = 1'b1;
    mc_rsp_v     = 1'b1;
    mc_rsp_data  = mk_rsp(32'h8A5, 32'h0);
    out_credits  = 5'd16;
    fence        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mc_req_v",   128'(mc_req_v_o),     128'(0));
    check("rst_req_ready",  128'(req_ready_o),    128'(0));
    check("rst_rsp_v",      128'(rsp_v_o),        128'(0));
    check("rst_mc_rsp_rdy", 128'(mc_rsp_ready_o), 128'(0));
    check("rst_fence_done", 128'(fence_done_o),   128'(0));
    check("rst_err",        128'(err_o),          128'(0));
    tick();
    req_v = '0; mc_rsp_v = 1'b0; fence = 1'b0; mc_req_ready = 1'b0;
    reset_i = 1'b0;
    tick();

    // ---------------- round-robin fairness ----------------
    gcnt0 = 0; gcnt1 = 0;
    req_data[0] = mk_req(op_st, 32'h1111_0000, 32'h100, 8'd0);
    req_data[1] = mk_req(op_st, 32'h2222_0000, 32'h200, 8'd1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) req_q.push_back('{oh: 2'b01, data: req_data[0]});
      else            req_q.push_back('{oh: 2'b10, data: req_data[1]});
    end
    req_v = 2'b11; mc_req_ready = 1'b1;
    repeat (8) tick();
    req_v = '0;
    check("fair_cnt0", 128'(gcnt0), 128'(4));
    check("fair_cnt1", 128'(gcnt1), 128'(4));

    // One req0 store so the pointer favours req1 before the lock test.
    req_q.push_back('{oh: 2'b01, data: req_data[0]});
    req_v = 2'b01;
    tick();
    req_v = '0;

    // ---------------- lock stability ----------------
    req_data[0] = mk_req(op_st, 32'h0000_C0C0, 32'h300, 8'd0);
    req_v = 2'b01; mc_req_ready = 1'b0;
    req_q.push_back('{oh: 2'b01, data: req_data[0]});
    @(negedge clk);
    check("lock_c1_v",    128'(mc_req_v_o), 128'(1));
    check("lock_c1_data", mc_req_data_o, req_data[0]);
    tick();
    req_data[1] = mk_req(op_st, 32'h0000_D0D0, 32'h400, 8'd1);
    req_v = 2'b11;
    @(negedge clk);
    check("lock_c2_data",  mc_req_data_o, req_data[0]);
    check("lock_c2_ready", 128'(req_ready_o), 128'(0));
    tick();
    @(negedge clk);
    check("lock_c3_data", mc_req_data_o, req_data[0]);
    tick();
    mc_req_ready = 1'b1;
    req_q.push_back('{oh: 2'b10, data: req_data[1]});
    tick();
    req_v = 2'b10;
    tick();
    req_v = '0;

    // ---------------- tag and route ----------------
    req_data[1] = mk_req(op_ld, 32'h0000_0FFF, 32'h500, 8'd1);
    req_q.push_back('{oh: 2'b10, data: mk_req(op_ld, 32'h0000_0FFF, 32'h500, 8'd1)});
    req_v = 2'b10;
    tick();
    req_data[0] = mk_req(op_ld, 32'h0000_0FFF, 32'h600, 8'd0);
    req_q.push_back('{oh: 2'b01, data: mk_req(op_ld, 32'h0000_07FF, 32'h600, 8'd0)});
    req_v = 2'b01;
    tick();
    req_v = '0;
    mc_rsp_data = mk_rsp(32'h8A5, 32'hDEAD_BEEF);
    mc_rsp_v = 1'b1; rsp_ready = 2'b00;
    @(negedge clk);
    check("route_stall_v",   128'(rsp_v_o),        128'(2'b10));
    check("route_stall_rdy", 128'(mc_rsp_ready_o), 128'(0));
    tick();
    rsp_ready = 2'b11;
    rsp_q.push_back('{oh: 2'b10, data: mk_rsp(32'h0A5, 32'hDEAD_BEEF)});
    tick();
    mc_rsp_data = mk_rsp(32'h0A5, 32'h0BAD_F00D);
    rsp_q.push_back('{oh: 2'b01, data: mk_rsp(32'h0A5, 32'h0BAD_F00D)});
    tick();
    mc_rsp_v = 1'b0;
    @(negedge clk);
    check("route_no_err", 128'(err_o), 128'(0));
    tick();

    // ---------------- outstanding limit ----------------
    ld0     = mk_req(op_ld, 32'h0000_0ABC, 32'h700, 8'd0);
    ld0_exp = mk_req(op_ld, 32'h0000_02BC, 32'h700, 8'd0);
    req_data[0] = ld0;
    for (int i = 0; i < 8; i++) req_q.push_back('{oh: 2'b01, data: ld0_exp});
    req_v = 2'b01;
    repeat (8) tick();
    req_data[1] = mk_req(op_st, 32'h0000_EEEE, 32'h800, 8'd1);
    req_q.push_back('{oh: 2'b10, data: req_data[1]});
    req_q.push_back('{oh: 2'b10, data: req_data[1]});
    req_v = 2'b11;
    repeat (2) tick();
    req_v = 2'b01;
    @(negedge clk);
    check("limit_block_v",   128'(mc_req_v_o),  128'(0));
    check("limit_block_rdy", 128'(req_ready_o), 128'(0));
    tick();
    mc_rsp_data = mk_rsp(32'h005, 32'h0000_0001);
    mc_rsp_v = 1'b1;
    rsp_q.push_back('{oh: 2'b01, data: mk_rsp(32'h005, 32'h0000_0001)});
    @(negedge clk);
    check("limit_same_cyc_v", 128'(mc_req_v_o), 128'(0));
    tick();
    mc_rsp_v = 1'b0;
    req_q.push_back('{oh: 2'b01, data: ld0_exp});
    tick();
    req_v = '0;

    // Drain five of the eight, leaving three outstanding on req0.
    mc_rsp_v = 1'b1;
    for (int i = 0; i < 5; i++) rsp_q.push_back('{oh: 2'b01, data: mc_rsp_data});
    repeat (5) tick();
    mc_rsp_v = 1'b0;

    // ---------------- fence ----------------
    out_credits = 5'd13; fence = 1'b1;
    req_data[0] = mk_req(op_st, 32'h0000_00F0, 32'h900, 8'd0);
    req_data[1] = mk_req(op_st, 32'h0000_00F1, 32'hA00, 8'd1);
    req_v = 2'b11;
    @(negedge clk);
    check("fence_entry_v", 128'(mc_req_v_o), 128'(0));
    tick();
    @(negedge clk);
    check("fence_no_grant", 128'(mc_req_v_o),   128'(0));
    check("fence_not_done", 128'(fence_done_o), 128'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      mc_rsp_v = 1'b1;
      mc_rsp_data = mk_rsp(32'h005, 32'h100 + 32'(i));
      rsp_q.push_back('{oh: 2'b01, data: mc_rsp_data});
      @(negedge clk);
      check("fence_drain_v",    128'(mc_req_v_o),   128'(0));
      check("fence_drain_done", 128'(fence_done_o), 128'(0));
      tick();
    end
    mc_rsp_v = 1'b0;
    @(negedge clk);
    check("fence_wait_cred", 128'(fence_done_o), 128'(0));
    tick();
    out_credits = 5'd16;
    @(negedge clk);
    check("fence_done",   128'(fence_done_o), 128'(1));
    check("fence_done_v", 128'(mc_req_v_o),   128'(0));
    tick();
    fence = 1'b0;
    req_q.push_back('{oh: 2'b10, data: req_data[1]});
    req_q.push_back('{oh: 2'b01, data: req_data[0]});
    @(negedge clk);
    check("fence_exit_v", 128'(mc_req_v_o), 128'(0));
    repeat (3) tick();
    req_v = '0;

    // ---------------- one-cycle fence pulse ----------------
    req_v = 2'b01; fence = 1'b1;
    @(negedge clk);
    check("pulse_idle_v", 128'(mc_req_v_o), 128'(0));
    tick();
    fence = 1'b0;
    @(negedge clk);
    check("pulse_fence_v", 128'(mc_req_v_o), 128'(0));
    tick();
    req_q.push_back('{oh: 2'b01, data: req_data[0]});
    tick();
    req_v = '0;

    // ---------------- unexpected response ----------------
    mc_rsp_data = mk_rsp(32'h800, 32'h0000_0077);
    mc_rsp_v = 1'b1; rsp_ready = 2'b00;
    @(negedge clk);
    check("err_drop_rdy", 128'(mc_rsp_ready_o), 128'(1));
    check("err_drop_v",   128'(rsp_v_o),        128'(0));
    check("err_not_yet",  128'(err_o),          128'(0));
    tick();
    mc_rsp_v = 1'b0;
    @(negedge clk);
    check("err_set", 128'(err_o), 128'(1));
    repeat (4) tick();
    @(negedge clk);
    check("err_sticky", 128'(err_o), 128'(1));
    tick();
    reset_i = 1'b1;
    tick();
    @(negedge clk);
    check("err_cleared", 128'(err_o), 128'(0));
    tick();
    reset_i = 1'b0;
    tick();

    check("req_q_drained", 128'(req_q.size()), 128'(0));
    check("rsp_q_drained", 128'(rsp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
